// File: rtl/vector_register_file_sb.sv
// vector_register_file_sb
//   Vector register file with REG_COUNT registers of LANES x LANE_WIDTH bits.
//   It has two combinational read ports and one lane-masked write port.
//   A write-through bypass lets reads see data being written in the same cycle.
//   A busy-bit scoreboard lets decode detect RAW and WAW hazards against
//   writebacks that are still in flight.
//
// Ports
//   clk                 rising-edge clock for all state
//   reset               asynchronous, active-low; clears data and busy bits
//   regWrEn             writeback strobe
//   regToWrite          writeback destination register
//   laneMask            per-lane write enable (bit i gates lane i)
//   dataIn              write data, lane i at [i*LANE_WIDTH +: LANE_WIDTH]
//   rSel1, rSel2        read selects
//   reg1Out, reg2Out    read data (bypassed)
//   resvEn, resvSel     reserve a destination for an issued instruction
//   flush               synchronous clear of every busy bit
//   rs1Busy, rs2Busy    read source still has a pending writer
//   resvBusy            reserve target already has a pending writer (WAW)
//   stall               rs1Busy | rs2Busy | (resvEn & resvBusy)
module vector_register_file_sb #(
  parameter int LANE_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int REG_COUNT  = 8,
  parameter int SEL_BITS   = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        regWrEn,
  input  logic [SEL_BITS-1:0]         regToWrite,
  input  logic [LANES-1:0]            laneMask,
  input  logic [LANES*LANE_WIDTH-1:0] dataIn,
  input  logic [SEL_BITS-1:0]         rSel1,
  input  logic [SEL_BITS-1:0]         rSel2,
  output logic [LANES*LANE_WIDTH-1:0] reg1Out,
  output logic [LANES*LANE_WIDTH-1:0] reg2Out,
  input  logic                        resvEn,
  input  logic [SEL_BITS-1:0]         resvSel,
  input  logic                        flush,
  output logic                        rs1Busy,
  output logic                        rs2Busy,
  output logic                        resvBusy,
  output logic                        stall
);

  localparam int VecWidth = LANES * LANE_WIDTH;

  // The select width must address exactly REG_COUNT registers. This also
  // forces REG_COUNT to be a power of two.
  generate
    if (((1 << SEL_BITS) != REG_COUNT) || (REG_COUNT < 2)) begin : gBadParams
      $error("vector_register_file_sb: SEL_BITS must equal log2(REG_COUNT), REG_COUNT >= 2");
    end
  endgenerate

  logic [VecWidth-1:0]  regArray [REG_COUNT];
  logic [REG_COUNT-1:0] busyReg;
  logic [REG_COUNT-1:0] busyNext;

  // Expand the lane mask into a bit mask once. The write path and both bypass
  // paths then share it.
  logic [VecWidth-1:0] wrBits;
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : gLaneMask
      assign wrBits[gi*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{laneMask[gi]}};
    end
  endgenerate

  // Data storage
  // This is a flop array rather than block RAM. Reads must be zero-latency,
  // and reset must clear every entry asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        regArray[r] <= '0;
      end
    end else if (regWrEn) begin
      regArray[regToWrite] <= (regArray[regToWrite] & ~wrBits) | (dataIn & wrBits);
    end
  end

  // Read ports with write-through bypass
  logic wrHit1;
  logic wrHit2;
  logic wrHitResv;

  assign wrHit1    = regWrEn && (regToWrite == rSel1);
  assign wrHit2    = regWrEn && (regToWrite == rSel2);
  assign wrHitResv = regWrEn && (regToWrite == resvSel);

  assign reg1Out = wrHit1 ? ((regArray[rSel1] & ~wrBits) | (dataIn & wrBits))
                          : regArray[rSel1];
  assign reg2Out = wrHit2 ? ((regArray[rSel2] & ~wrBits) | (dataIn & wrBits))
                          : regArray[rSel2];

  // Scoreboard
  // The clear is applied before the set. When a reserve and a write hit the
  // same register, the bit therefore ends at 1, because a new writer is pending.
  always_comb begin
    busyNext = busyReg;
    if (flush) begin
      busyNext = '0;
    end else begin
      if (regWrEn) busyNext[regToWrite] = 1'b0;
      if (resvEn)  busyNext[resvSel]    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busyReg <= '0;
    end else begin
      busyReg <= busyNext;
    end
  end

  // A register whose writer completes this cycle is not a hazard. Its data is
  // already visible through the bypass.
  assign rs1Busy  = busyReg[rSel1]   & ~wrHit1;
  assign rs2Busy  = busyReg[rSel2]   & ~wrHit2;
  assign resvBusy = busyReg[resvSel] & ~wrHitResv;
  assign stall    = rs1Busy | rs2Busy | (resvEn & resvBusy);

endmodule

// File: tb/tb_vector_register_file_sb.sv
module tb_vector_register_file_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        regWrEn;
  logic [2:0]  regToWrite;
  logic [3:0]  laneMask;
  logic [63:0] dataIn;
  logic [2:0]  rSel1;
  logic [2:0]  rSel2;
  logic [63:0] reg1Out;
  logic [63:0] reg2Out;
  logic        resvEn;
  logic [2:0]  resvSel;
  logic        flush;
  logic        rs1Busy;
  logic        rs2Busy;
  logic        resvBusy;
  logic        stall;

  always #5 clk = ~clk;

  vector_register_file_sb dut (
    .clk(clk), .reset(reset),
    .regWrEn(regWrEn), .regToWrite(regToWrite), .laneMask(laneMask), .dataIn(dataIn),
    .rSel1(rSel1), .rSel2(rSel2), .reg1Out(reg1Out), .reg2Out(reg2Out),
    .resvEn(resvEn), .resvSel(resvSel), .flush(flush),
    .rs1Busy(rs1Busy), .rs2Busy(rs2Busy), .resvBusy(resvBusy), .stall(stall)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] expQ[$];
  logic [63:0] exp;

  // Stimulus helpers (no checking inside)
  task automatic idle();
    regWrEn = 0; regToWrite = 0; laneMask = 0; dataIn = 0;
    rSel1 = 0; rSel2 = 0; resvEn = 0; resvSel = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle(); reset = 0;
    rSel1 = 3;
    #3;
    expQ.push_back(64'h0); expQ.push_back(64'h0);
    exp = expQ.pop_front(); checks++;
    if (reg1Out !== exp) begin errors++; $display("FAIL reset_init_data: got %h expected %h", reg1Out, exp); end
    exp = expQ.pop_front(); checks++;
    if ({63'h0, stall} !== exp) begin errors++; $display("FAIL reset_init_stall: got %h expected %h", stall, exp); end
    tick(); reset = 1;
    // Write R3 and reserve R5
    regWrEn = 1; regToWrite = 3; laneMask = 4'hF; dataIn = 64'hAAAA_AAAA_AAAA_AAAA;
    resvEn = 1; resvSel = 5;
    tick(); idle(); rSel1 = 3; rSel2 = 5;
    #1;
    expQ.push_back(64'hAAAA_AAAA_AAAA_AAAA); expQ.push_back(64'h1);
    exp = expQ.pop_front(); checks++;
    if (reg1Out !== exp) begin errors++; $display("FAIL reset_prewrite: got %h expected %h", reg1Out, exp); end
    exp = expQ.pop_front(); checks++;
    if ({63'h0, rs2Busy} !== exp) begin errors++; $display("FAIL reset_prebusy: got %h expected %h", rs2Busy, exp); end
    // Pulse reset between edges; outputs must clear with no clock edge
    #1; reset = 0; #1;
    expQ.push_back(64'h0); expQ.push_back(64'h0);
    exp = expQ.pop_front(); checks++;
    if (reg1Out !== exp) begin errors++; $display("FAIL reset_async_data: got %h expected %h", reg1Out, exp); end
    exp = expQ.pop_front(); checks++;
    if ({63'h0, rs2Busy} !== exp) begin errors++; $display("FAIL reset_async_busy: got %h expected %h", rs2Busy, exp); end
    #1; reset = 1;
    tick();
  endtask

  task automatic test_masked_write();
    idle();
    regWrEn = 1; regToWrite = 2; laneMask = 4'hF; dataIn = 64'h1111_2222_3333_4444;
    tick();
    laneMask = 4'b0101; dataIn = 64'hAAAA_BBBB_CCCC_DDDD;
    tick(); idle(); rSel1 = 2; rSel2 = 2;
    #1;
    expQ.push_back(64'h1111_BBBB_3333_DDDD); expQ.push_back(64'h1111_BBBB_3333_DDDD);
    exp = expQ.pop_front(); checks++;
    if (reg1Out !== exp) begin errors++; $display("FAIL masked_write_p1: got %h expected %h", reg1Out, exp); end
    exp = expQ.pop_front(); checks++;
    if (reg2Out !== exp) begin errors++; $display("FAIL masked_write_p2: got %h expected %h", reg2Out, exp); end
    // laneMask=0 changes nothing
    regWrEn = 1; regToWrite = 2; laneMask = 4'b0000; dataIn = 64'hFFFF_FFFF_FFFF_FFFF;
    tick(); idle(); rSel1 = 2;
    #1;
    expQ.push_back(64'h1111_BBBB_3333_DDDD);
    exp = expQ.pop_front(); checks++;
    if (reg1Out !== exp) begin errors++; $display("FAIL masked_write_zero_mask: got %h expected %h", reg1Out, exp); end
  endtask

  task automatic test_bypass();
    idle();
    regWrEn = 1; regToWrite = 5; laneMask = 4'hF; dataIn = 64'h1234_5678_9ABC_DEF0;
    tick();
    rSel1 = 5; rSel2 = 5; dataIn = 64'h0F0F_0F0F_0F0F_0F0F;
    #1;
    expQ.push_back(64'h0F0F_0F0F_0F0F_0F0F); expQ.push_back(64'h0F0F_0F0F_0F0F_0F0F);
    exp = expQ.pop_front(); checks++;
    if (reg1Out !== exp) begin errors++; $display("FAIL bypass_full_p1: got %h expected %h", reg1Out, exp); end
    exp = expQ.pop_front(); checks++;
    if (reg2Out !== exp) begin errors++; $display("FAIL bypass_full_p2: got %h expected %h", reg2Out, exp); end
    tick();
    // Partial bypass: the low two lanes come from dataIn, the rest from storage
    laneMask = 4'b0011; dataIn = 64'hEEEE_EEEE_5555_6666; rSel2 = 1;
    #1;
    expQ.push_back(64'h0F0F_0F0F_5555_6666); expQ.push_back(64'h0);
    exp = expQ.pop_front(); checks++;
    if (reg1Out !== exp) begin errors++; $display("FAIL bypass_partial_p1: got %h expected %h", reg1Out, exp); end
    exp = expQ.pop_front(); checks++;
    if (reg2Out !== exp) begin errors++; $display("FAIL bypass_other_reg_p2: got %h expected %h", reg2Out, exp); end
    tick(); idle();
  endtask

  task automatic test_raw();
    idle();
    resvEn = 1; resvSel = 4;
    tick(); idle(); rSel1 = 4; rSel2 = 0;
    #1;
    expQ.push_back(64'h1); expQ.push_back(64'h1);
    exp = expQ.pop_front(); checks++;
    if ({63'h0, rs1Busy} !== exp) begin errors++; $display("FAIL raw_rs1busy: got %h expected %h", rs1Busy, exp); end
    exp = expQ.pop_front(); checks++;
    if ({63'h0, stall} !== exp) begin errors++; $display("FAIL raw_stall: got %h expected %h", stall, exp); end
    regWrEn = 1; regToWrite = 4; laneMask = 4'hF; dataIn = 64'h4444_4444_4444_4444;
    #1;
    expQ.push_back(64'h0); expQ.push_back(64'h0);
    exp = expQ.pop_front(); checks++;
    if ({63'h0, rs1Busy} !== exp) begin errors++; $display("FAIL raw_complete_rs1busy: got %h expected %h", rs1Busy, exp); end
    exp = expQ.pop_front(); checks++;
    if ({63'h0, stall} !== exp) begin errors++; $display("FAIL raw_complete_stall: got %h expected %h", stall, exp); end
    tick(); idle(); rSel2 = 4;
    #1;
    expQ.push_back(64'h0);
    exp = expQ.pop_front(); checks++;
    if ({63'h0, rs2Busy} !== exp) begin errors++; $display("FAIL raw_after_edge: got %h expected %h", rs2Busy, exp); end
  endtask

  task automatic test_simultaneous();
    idle();
    resvEn = 1; resvSel = 6; regWrEn = 1; regToWrite = 6; laneMask = 4'hF; dataIn = 64'h6;
    tick(); idle(); rSel1 = 6;
    #1;
    expQ.push_back(64'h1);
    exp = expQ.pop_front(); checks++;
    if ({63'h0, rs1Busy} !== exp) begin errors++; $display("FAIL simul_resv_wins: got %h expected %h", rs1Busy, exp); end
    resvEn = 1; resvSel = 7; flush = 1;
    tick(); idle(); rSel1 = 7; rSel2 = 6;
    #1;
    expQ.push_back(64'h0); expQ.push_back(64'h0);
    exp = expQ.pop_front(); checks++;
    if ({63'h0, rs1Busy} !== exp) begin errors++; $display("FAIL flush_over_resv: got %h expected %h", rs1Busy, exp); end
    exp = expQ.pop_front(); checks++;
    if ({63'h0, rs2Busy} !== exp) begin errors++; $display("FAIL flush_clears: got %h expected %h", rs2Busy, exp); end
  endtask

  task automatic test_waw();
    idle();
    resvEn = 1; resvSel = 1;
    tick();
    // Reserve R1 again while it is busy; rSel1/rSel2=0 are idle
    #1;
    expQ.push_back(64'h1); expQ.push_back(64'h1);
    exp = expQ.pop_front(); checks++;
    if ({63'h0, resvBusy} !== exp) begin errors++; $display("FAIL waw_resvbusy: got %h expected %h", resvBusy, exp); end
    exp = expQ.pop_front(); checks++;
    if ({63'h0, stall} !== exp) begin errors++; $display("FAIL waw_stall: got %h expected %h", stall, exp); end
    regWrEn = 1; regToWrite = 1; laneMask = 4'hF; dataIn = 64'h1;
    #1;
    expQ.push_back(64'h0); expQ.push_back(64'h0);
    exp = expQ.pop_front(); checks++;
    if ({63'h0, resvBusy} !== exp) begin errors++; $display("FAIL waw_complete_resvbusy: got %h expected %h", resvBusy, exp); end
    exp = expQ.pop_front(); checks++;
    if ({63'h0, stall} !== exp) begin errors++; $display("FAIL waw_complete_stall: got %h expected %h", stall, exp); end
    idle(); flush = 1;
    tick(); idle();
  endtask

  // Random back-to-back traffic against an independent reference model
  task automatic test_back_to_back();
    logic [63:0] model [8];
    logic [7:0]  mBusy;
    logic [63:0] e1, e2;
    logic        eb1, eb2, ebr, est;
    idle(); reset = 0; #2; reset = 1;
    for (int r = 0; r < 8; r++) model[r] = 64'h0;
    mBusy = 8'h0;
    tick();
    for (int n = 0; n < 60; n++) begin
      regWrEn = 1'($urandom_range(0, 1)); regToWrite = 3'($urandom);
      laneMask = 4'($urandom); dataIn = {$urandom, $urandom};
      rSel1 = 3'($urandom); rSel2 = 3'($urandom);
      resvEn = 1'($urandom_range(0, 1)); resvSel = 3'($urandom);
      flush = ($urandom_range(0, 15) == 0);
      e1 = model[rSel1]; e2 = model[rSel2];
      for (int l = 0; l < 4; l++) begin
        if (regWrEn && laneMask[l] && regToWrite == rSel1) e1[l*16 +: 16] = dataIn[l*16 +: 16];
        if (regWrEn && laneMask[l] && regToWrite == rSel2) e2[l*16 +: 16] = dataIn[l*16 +: 16];
      end
      eb1 = mBusy[rSel1]   && !(regWrEn && regToWrite == rSel1);
      eb2 = mBusy[rSel2]   && !(regWrEn && regToWrite == rSel2);
      ebr = mBusy[resvSel] && !(regWrEn && regToWrite == resvSel);
      est = eb1 || eb2 || (resvEn && ebr);
      expQ.push_back(e1); expQ.push_back(e2);
      expQ.push_back({60'h0, eb1, eb2, ebr, est});
      #1;
      exp = expQ.pop_front(); checks++;
      if (reg1Out !== exp) begin errors++; $display("FAIL b2b_reg1 cyc%0d: got %h expected %h", n, reg1Out, exp); end
      exp = expQ.pop_front(); checks++;
      if (reg2Out !== exp) begin errors++; $display("FAIL b2b_reg2 cyc%0d: got %h expected %h", n, reg2Out, exp); end
      exp = expQ.pop_front(); checks++;
      if ({60'h0, rs1Busy, rs2Busy, resvBusy, stall} !== exp) begin
        errors++;
        $display("FAIL b2b_flags cyc%0d: got %b expected %b", n, {rs1Busy, rs2Busy, resvBusy, stall}, exp[3:0]);
      end
      // Advance the model with the same inputs the DUT sees at the edge
      if (regWrEn)
        for (int l = 0; l < 4; l++)
          if (laneMask[l]) model[regToWrite][l*16 +: 16] = dataIn[l*16 +: 16];
      if (flush) mBusy = 8'h0;
      else begin
        if (regWrEn) mBusy[regToWrite] = 1'b0;
        if (resvEn)  mBusy[resvSel]    = 1'b1;
      end
      $display("b2b cyc%0d wr=%0b sel=%0d mask=%b r1=%0d r2=%0d resv=%0b/%0d flush=%0b",
               n, regWrEn, regToWrite, laneMask, rSel1, rSel2, resvEn, resvSel, flush);
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_masked_write();
    test_bypass();
    test_raw();
    test_simultaneous();
    test_waw();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
